// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity-mode codes and a 3-sample vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic BRclk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge BRclk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: majority-voted bits, optional parity, 1/2 stop bits,
// break detection and a single-word valid/ready output holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 BRclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_READY,
    output logic                 RX_PERR,
    output logic                 RX_FERR,
    output logic                 RX_OVERRUN,
    output logic                 RX_BUSY
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    rx_state_t state, state_nxt;

    logic                 rxs;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_idx;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 stop_one;

    logic tick_wrap_c;
    logic maj_tick_c;
    logic maj_c;
    logic frame_done_c;
    logic break_c;
    logic perr_c;
    logic ferr_c;

    uart_rx_sync u_sync (
        .BRclk (BRclk),
        .reset (reset),
        .din   (UART_RX),
        .dout  (rxs)
    );

    // Bit-timing and frame-completion decode
    always_comb begin
        tick_wrap_c  = (tick == TICK_LAST);
        maj_tick_c   = (tick == TICK_S2);
        maj_c        = maj3(samp[0], samp[1], rxs);
        frame_done_c = (state == ST_STOP) && maj_tick_c && (bit_idx == LAST_STOP);
        ferr_c       = ferr_acc | ~maj_c;
        break_c      = (shreg == '0) && !(stop_one | maj_c);
        perr_c       = 1'b0;
        if (PARITY == PAR_EVEN) begin
            perr_c = ^{shreg, par_bit};
        end else if (PARITY == PAR_ODD) begin
            perr_c = ~^{shreg, par_bit};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!rxs) state_nxt = ST_START;
            ST_START: begin
                if (maj_tick_c && maj_c) begin
                    state_nxt = ST_IDLE;
                end else if (tick_wrap_c) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_wrap_c && (bit_idx == LAST_DATA)) begin
                    state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick_wrap_c) state_nxt = ST_STOP;
            ST_STOP:   if (frame_done_c) state_nxt = break_c ? ST_BREAK : ST_IDLE;
            ST_BREAK:  if (rxs) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge BRclk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sampling datapath and output holding register
    always_ff @(posedge BRclk or negedge reset) begin
        if (!reset) begin
            tick       <= '0;
            bit_idx    <= '0;
            samp       <= 2'b11;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            stop_one   <= 1'b0;
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            RX_PERR    <= 1'b0;
            RX_FERR    <= 1'b0;
            RX_OVERRUN <= 1'b0;
            RX_BUSY    <= 1'b0;
        end else begin
            RX_OVERRUN <= 1'b0;
            RX_BUSY    <= (state_nxt != ST_IDLE);

            if (state == ST_IDLE) begin
                tick     <= '0;
                bit_idx  <= '0;
                ferr_acc <= 1'b0;
                stop_one <= 1'b0;
            end else if (state != ST_BREAK) begin
                tick <= tick_wrap_c ? '0 : tick + 1'b1;
                if (tick == TICK_S0) samp[0] <= rxs;
                if (tick == TICK_S1) samp[1] <= rxs;
                if (maj_tick_c) begin
                    case (state)
                        ST_DATA:   shreg <= {maj_c, shreg[DATA_BITS-1:1]};
                        ST_PARITY: par_bit <= maj_c;
                        ST_STOP: begin
                            ferr_acc <= ferr_c;
                            stop_one <= stop_one | maj_c;
                        end
                        default: ;
                    endcase
                end
                if (tick_wrap_c && (state == ST_DATA || state == ST_STOP)) begin
                    bit_idx <= (bit_idx == LAST_DATA && state == ST_DATA) ? '0 : bit_idx + 1'b1;
                end
            end

            // A completing frame may replace a word being consumed in the same cycle
            if (frame_done_c) begin
                if (!RX_VALID || RX_READY) begin
                    RX_DATA  <= shreg;
                    RX_PERR  <= perr_c;
                    RX_FERR  <= ferr_c;
                    RX_VALID <= 1'b1;
                end else begin
                    RX_OVERRUN <= 1'b1;
                end
            end else if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed frame scenarios plus randomized frames scored against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int unsigned OS = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] rx_line;
    logic [1:0] ready, ready_force, rnd_ready;
    logic       rand_ready;
    logic [7:0] data [2];
    logic [1:0] valid, perr, ferr, ovr, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ovr_cnt0 = 0;
    int   rise0 = 0;
    logic v0_d = 1'b0;
    bit   mon_en = 1'b0;
    bit   hold [2];
    logic [9:0] prev [2];
    exp_t q0[$];
    exp_t q1[$];
    exp_t me;

    assign ready = rand_ready ? rnd_ready : ready_force;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_NONE), .STOP_BITS(1)) u_dut0 (
        .BRclk(clk), .reset(rst_n), .UART_RX(rx_line[0]), .RX_DATA(data[0]), .RX_VALID(valid[0]),
        .RX_READY(ready[0]), .RX_PERR(perr[0]), .RX_FERR(ferr[0]), .RX_OVERRUN(ovr[0]), .RX_BUSY(busy[0]));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_dut1 (
        .BRclk(clk), .reset(rst_n), .UART_RX(rx_line[1]), .RX_DATA(data[1]), .RX_VALID(valid[1]),
        .RX_READY(ready[1]), .RX_PERR(perr[1]), .RX_FERR(ferr[1]), .RX_OVERRUN(ovr[1]), .RX_BUSY(busy[1]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        rnd_ready = 2'($urandom_range(0, 3));
    end

    always @(negedge clk) begin
        if (ovr[0]) ovr_cnt0++;
        if (valid[0] && !v0_d) rise0 = cyc;
        v0_d = valid[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: parity by counting ones, framing by any low stop bit
    function automatic exp_t model(input logic [7:0] d, input int pm, input logic pb,
                                   input logic [1:0] stops, input int nstop);
        exp_t e;
        int ones;
        ones = int'(pb);
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        e.d = d;
        e.p = (pm == 0) ? 1'b0 : (pm == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
        e.f = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        return e;
    endfunction

    task automatic send_frame(input int w, input logic [7:0] d, input int pm, input logic pb,
                              input logic [1:0] stops, input int nstop, input int glitch_bit);
        logic [12:0] bits;
        int n;
        bits = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pm != 0) begin
            bits[n] = pb;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stops[i];
            n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < int'(OS); t++) begin
                rx_line[w] = (b == glitch_bit && t == int'(OS / 2)) ? ~bits[b] : bits[b];
                @(negedge clk);
            end
        end
        rx_line[w] = 1'b1;
    endtask

    task automatic rand_frame(input int w);
        logic [7:0] d;
        logic [1:0] st;
        logic pb;
        int pm, ns;
        d = 8'($urandom);
        if ($urandom_range(0, 7) == 0) d = 8'h00;
        st = 2'b11;
        if ($urandom_range(0, 5) == 0) st[0] = 1'b0;
        if (w == 1 && $urandom_range(0, 5) == 0) st[1] = 1'b0;
        pm = (w == 0) ? 0 : 1;
        ns = (w == 0) ? 1 : 2;
        pb = 1'($urandom_range(0, 1));
        if (w == 0) q0.push_back(model(d, pm, pb, st, ns));
        else        q1.push_back(model(d, pm, pb, st, ns));
        send_frame(w, d, pm, pb, st, ns, -1);
        repeat (2 * OS + $urandom_range(0, 15)) @(negedge clk);
    endtask

    task automatic accept(input int w);
        ready_force[w] = 1'b1;
        @(negedge clk);
        ready_force[w] = 1'b0;
        chk($sformatf("accept%0d_valid", w), 32'(valid[w]), 32'd0);
    endtask

    // Scoreboard compare on every cycle while random traffic runs
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] && valid[i])
                    chk($sformatf("hold%0d", i), 32'({data[i], perr[i], ferr[i]}), 32'(prev[i]));
                if (valid[i] && ready[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL word%0d: unexpected word %0h, none pending", i, data[i]);
                    end else begin
                        if (i == 0) me = q0.pop_front();
                        else        me = q1.pop_front();
                        chk($sformatf("word%0d", i), 32'({data[i], perr[i], ferr[i]}), 32'(me));
                    end
                end
                chk($sformatf("no_overrun%0d", i), 32'(ovr[i]), 32'd0);
                hold[i] = valid[i] && !ready[i];
                prev[i] = {data[i], perr[i], ferr[i]};
            end
        end
    end

    initial begin
        exp_t pin;
        int start_cyc, lat, base;
        rst_n = 1'b0;
        rx_line = 2'b11;
        ready_force = 2'b00;
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data0", 32'(data[0]), 32'd0);
        chk("rst_flags", 32'({perr, ferr, ovr}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        pin = model(8'h03, 1, 1'b1, 2'b11, 2);
        chk("model_even_err", 32'(pin.p), 32'd1);
        pin = model(8'h07, 2, 1'b0, 2'b11, 2);
        chk("model_odd_ok", 32'(pin.p), 32'd0);
        pin = model(8'h5A, 1, 1'b0, 2'b01, 2);
        chk("model_stop2", 32'({pin.p, pin.f}), 32'b01);

        // Clean 8'hA5 frame and its latency from the falling edge
        start_cyc = cyc;
        send_frame(0, 8'hA5, 0, 1'b0, 2'b11, 1, -1);
        repeat (4) @(negedge clk);
        chk("a5_word", 32'({valid[0], data[0], perr[0], ferr[0]}), 32'({1'b1, 8'hA5, 2'b00}));
        lat = rise0 - start_cyc - 1;
        checks++;
        if (lat < 154 || lat > 156) begin
            errors++;
            $display("FAIL a5_latency: got %0d cycles expected 155 +/-1", lat);
        end
        accept(0);

        // Short low glitch on idle line is a false start
        rx_line[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_busy", 32'(busy[0]), 32'd1);
        repeat (40) @(negedge clk);
        chk("glitch_idle", 32'({valid[0], busy[0]}), 32'd0);

        // Single-tick glitch in the middle of data bit 3 is voted out
        send_frame(0, 8'h00, 0, 1'b0, 2'b11, 1, 4);
        repeat (4) @(negedge clk);
        chk("midbit_glitch", 32'({valid[0], data[0], perr[0], ferr[0]}), 32'({1'b1, 8'h00, 2'b00}));
        accept(0);

        // Overrun with the consumer stalled, then simultaneous accept/complete
        base = ovr_cnt0;
        send_frame(0, 8'h11, 0, 1'b0, 2'b11, 1, -1);
        repeat (2 * OS) @(negedge clk);
        send_frame(0, 8'h22, 0, 1'b0, 2'b11, 1, -1);
        repeat (4) @(negedge clk);
        chk("ovr_held", 32'({valid[0], data[0]}), 32'({1'b1, 8'h11}));
        chk("ovr_pulses", 32'(ovr_cnt0 - base), 32'd1);
        repeat (2 * OS) @(negedge clk);
        fork
            send_frame(0, 8'h22, 0, 1'b0, 2'b11, 1, -1);
            begin
                repeat (156) @(negedge clk);
                ready_force[0] = 1'b1;
                @(negedge clk);
                ready_force[0] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("swap_word", 32'({valid[0], data[0]}), 32'({1'b1, 8'h22}));
        chk("swap_no_pulse", 32'(ovr_cnt0 - base), 32'd1);
        accept(0);

        // Line held low for 20 bit-times: one break word, busy until line returns high
        base = ovr_cnt0;
        rx_line[0] = 1'b0;
        repeat (300) @(negedge clk);
        chk("break_busy", 32'(busy[0]), 32'd1);
        repeat (20) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_idle", 32'(busy[0]), 32'd0);
        chk("break_word", 32'({valid[0], data[0], perr[0], ferr[0]}), 32'({1'b1, 8'h00, 2'b01}));
        chk("break_single", 32'(ovr_cnt0 - base), 32'd0);
        accept(0);
        repeat (2 * OS) @(negedge clk);
        send_frame(0, 8'h5A, 0, 1'b0, 2'b11, 1, -1);
        repeat (4) @(negedge clk);
        chk("after_break", 32'({valid[0], data[0], ferr[0]}), 32'({1'b1, 8'h5A, 1'b0}));

        // Reset mid-DATA while a word is still held
        for (int b = 0; b < 4; b++) begin
            rx_line[0] = (b == 0) ? 1'b0 : ((b == 3) ? 1'b0 : 1'b1);
            repeat (OS) @(negedge clk);
        end
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({valid[0], data[0], perr[0], ferr[0], ovr[0], busy[0]}), 32'd0);
        rx_line[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * OS) @(negedge clk);
        send_frame(0, 8'hC3, 0, 1'b0, 2'b11, 1, -1);
        repeat (4) @(negedge clk);
        chk("after_rst", 32'({valid[0], data[0], ferr[0]}), 32'({1'b1, 8'hC3, 1'b0}));
        accept(0);

        // Even parity, two stop bits
        send_frame(1, 8'h03, 1, 1'b1, 2'b11, 2, -1);
        repeat (4) @(negedge clk);
        chk("par_err", 32'({valid[1], data[1], perr[1], ferr[1]}), 32'({1'b1, 8'h03, 2'b10}));
        accept(1);
        repeat (2 * OS) @(negedge clk);
        send_frame(1, 8'h03, 1, 1'b0, 2'b11, 2, -1);
        repeat (4) @(negedge clk);
        chk("par_ok", 32'({valid[1], data[1], perr[1], ferr[1]}), 32'({1'b1, 8'h03, 2'b00}));
        accept(1);
        repeat (2 * OS) @(negedge clk);
        send_frame(1, 8'h81, 1, 1'b0, 2'b01, 2, -1);
        repeat (4) @(negedge clk);
        chk("stop2_ferr", 32'({valid[1], data[1], perr[1], ferr[1]}), 32'({1'b1, 8'h81, 2'b01}));
        accept(1);
        repeat (2 * OS) @(negedge clk);

        // Randomized traffic on both receivers with random consumer back-pressure
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        rand_ready = 1'b1;
        mon_en = 1'b1;
        fork
            for (int k = 0; k < 25; k++) rand_frame(0);
            for (int k = 0; k < 18; k++) rand_frame(1);
        join
        repeat (60) @(negedge clk);
        mon_en = 1'b0;
        rand_ready = 1'b0;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, BRclk ticks per bit, even, legal range 8..32.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked, 1 or 2.
REQ-005 SHALL have port BRclk  in  1  sampling clock at OVERSAMPLE x baud, single clock domain.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port UART_RX  in  1  serial line, asynchronous, idle high.
REQ-008 SHALL have port RX_DATA  out  DATA_BITS  received word, LSB first on line.
REQ-009 SHALL have port RX_VALID  out  1  RX_DATA/RX_PERR/RX_FERR hold a word.
REQ-010 SHALL have port RX_READY  in  1  consumer accepts word.
REQ-011 SHALL have port RX_PERR  out  1  parity error of held word (0 when PARITY=0).
REQ-012 SHALL have port RX_FERR  out  1  framing error of held word.
REQ-013 SHALL have port RX_OVERRUN  out  1  one-cycle pulse, completed frame dropped.
REQ-014 SHALL have port RX_BUSY  out  1  high in every state except IDLE.

Function
REQ-015 SHALL pass UART_RX through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 SHALL keep a tick counter 0..OVERSAMPLE-1, cleared on IDLE->START, wrapping to 0 at OVERSAMPLE-1 and advancing the bit index on wrap.
REQ-018 SHALL form each bit value as majority of rxs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-019 SHALL leave IDLE for START on the first cycle rxs=0.
REQ-020 SHALL return START->IDLE (false start, no output) if the start-bit majority is 1; otherwise enter DATA on tick wrap.
REQ-021 SHALL shift DATA_BITS majority values LSB first, then enter PARITY if PARITY!=0, else STOP.
REQ-022 SHALL set parity error when XOR of data bits and parity bit is 1 (even) or 0 (odd).
REQ-023 SHALL set framing error if any of the STOP_BITS stop-bit majorities is 0.
REQ-024 SHALL complete the frame on the cycle after the last stop-bit majority tick, not at end of bit, and go to IDLE, or to BREAK if all data bits and the stop bit are 0.
REQ-025 SHALL stay in BREAK until rxs=1, then go to IDLE; break frames deliver with RX_FERR=1.
REQ-026 SHALL on completion with RX_VALID=0, or RX_VALID=1 and RX_READY=1 in the same cycle, load RX_DATA/RX_PERR/RX_FERR and set RX_VALID.
REQ-027 SHALL on completion with RX_VALID=1 and RX_READY=0 keep the held word and pulse RX_OVERRUN one cycle.
REQ-028 SHALL clear RX_VALID on RX_VALID&RX_READY when no frame completes that cycle.
REQ-029 SHALL keep RX_DATA/RX_PERR/RX_FERR stable while RX_VALID=1 and RX_READY=0.

Reset
REQ-030 SHALL on reset=0 immediately force IDLE, counters 0, synchronizer flops 1, RX_DATA 0, RX_VALID/RX_PERR/RX_FERR/RX_OVERRUN/RX_BUSY 0.
REQ-031 SHALL discard any frame in progress on reset; after release, a line still low is treated as a new start.

Structure
REQ-032 SHALL take the state enum and parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD) from shared package uart_pkg.
REQ-033 SHALL instantiate one sub-module uart_rx_sync (2-flop synchronizer, reset value 1).

Verification
REQ-034 Defaults, byte 8'hA5, clean line -> RX_VALID with RX_DATA=8'hA5, RX_PERR=0, RX_FERR=0, RX_VALID 2+16*9+8+1 cycles after falling edge +/-1.
REQ-035 PARITY=1, 8'h03 with parity bit 1 -> RX_PERR=1, RX_DATA=8'h03; parity bit 0 -> RX_PERR=0.
REQ-036 Low glitch of 4 ticks on idle line -> return to IDLE, RX_VALID stays 0; single-tick glitch at data mid-bit of 8'h00 -> RX_DATA=8'h00.
REQ-037 RX_READY=0, two frames 8'h11 then 8'h22 -> RX_DATA=8'h11 held, one RX_OVERRUN pulse; RX_READY=1 on second completion cycle -> RX_DATA=8'h22, no pulse.
REQ-038 Line held low 20 bit-times -> one word 8'h00 with RX_FERR=1, RX_BUSY high until line high, next 8'h5A received correctly.
REQ-039 reset pulsed low mid-DATA -> all outputs 0 in same cycle, following frame 8'hC3 received correctly.
